// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - miss, memory-port and cache-array write signals of the line-fill engine
interface icache_refill_if #(
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5
);
    logic                    miss_req;
    logic [31:0]             miss_addr;
    logic                    miss_ready;
    logic                    refill_done;
    logic                    mem_req_valid;
    logic [31:0]             mem_req_addr;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [31:0]             mem_rsp_data;
    logic                    data_we;
    logic [INDEX_WIDTH-1:0]  data_index;
    logic [OFFSET_WIDTH-1:0] data_offset;
    logic [31:0]             data_wdata;
    logic                    tag_we;
    logic [TAG_WIDTH-1:0]    tag_wdata;
    logic                    valid_we;
    logic                    valid_wdata;

    modport master (
        input  miss_req, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output miss_ready, refill_done, mem_req_valid, mem_req_addr,
               data_we, data_index, data_offset, data_wdata,
               tag_we, tag_wdata, valid_we, valid_wdata
    );

    modport slave (
        output miss_req, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  miss_ready, refill_done, mem_req_valid, mem_req_addr,
               data_we, data_index, data_offset, data_wdata,
               tag_we, tag_wdata, valid_we, valid_wdata
    );
endinterface

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache line-fill engine; ICACHE_CRITICAL_WORD_FIRST_EN enables critical-word-first fetch
module icache_refill #(
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5
) (
    input  logic            clk,
    input  logic            reset,
    icache_refill_if.master bus
);
    localparam int WORD_BITS  = OFFSET_WIDTH - 2;
    localparam int COUNT_BITS = WORD_BITS + 1;
    localparam int WORDS      = 1 << WORD_BITS;

    typedef enum logic [2:0] {IDLE, INVAL, REQ, WAIT, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [WORD_BITS-1:0]   word_q;
    logic [WORD_BITS-1:0]   start_word;
    logic [COUNT_BITS-1:0]  count_q;
    logic                   rsp_fire;

    // A response only counts while a request is outstanding
    assign rsp_fire = (state_q == WAIT) && bus.mem_rsp_valid;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic unused_byte_sel;
    assign start_word      = bus.miss_addr[OFFSET_WIDTH-1:2];
    assign unused_byte_sel = ^bus.miss_addr[1:0];
`else
    logic unused_offset;
    assign start_word    = '0;
    assign unused_offset = ^bus.miss_addr[OFFSET_WIDTH-1:0];
`endif

    assign bus.data_index = index_q;

    // State register; reset abandons any refill in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the missing line on acceptance, advance word/count per response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q   <= '0;
            index_q <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else if (state_q == IDLE && bus.miss_req) begin
            tag_q   <= bus.miss_addr[31 -: TAG_WIDTH];
            index_q <= bus.miss_addr[OFFSET_WIDTH +: INDEX_WIDTH];
            word_q  <= start_word;
            count_q <= '0;
        end else if (rsp_fire) begin
            word_q  <= word_q + 1'b1;
            count_q <= count_q + 1'b1;
        end
    end

    // Next state and all port outputs; buses stay zero outside their active state
    always_comb begin
        state_d           = state_q;
        bus.miss_ready    = 1'b0;
        bus.refill_done   = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.data_we       = 1'b0;
        bus.data_offset   = '0;
        bus.data_wdata    = '0;
        bus.tag_we        = 1'b0;
        bus.tag_wdata     = '0;
        bus.valid_we      = 1'b0;
        bus.valid_wdata   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_req) begin
                    state_d = INVAL;
                end
            end
            INVAL: begin
                bus.valid_we = 1'b1;
                state_d      = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {tag_q, index_q, word_q, 2'b00};
                if (bus.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    bus.data_we     = 1'b1;
                    bus.data_offset = {word_q, 2'b00};
                    bus.data_wdata  = bus.mem_rsp_data;
                    state_d = (count_q == COUNT_BITS'(WORDS - 1)) ? COMMIT : REQ;
                end
            end
            COMMIT: begin
                bus.tag_we      = 1'b1;
                bus.tag_wdata   = tag_q;
                bus.valid_we    = 1'b1;
                bus.valid_wdata = 1'b1;
                bus.refill_done = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - self-checking bench for icache_refill with memory responder and cache-image model
module tb_icache_refill;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    icache_refill_if bus_if ();
    icache_refill dut (.clk(clk), .reset(reset), .bus(bus_if));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int stall_cfg = 0;
    int delay_cfg = 0;
    bit rand_mode = 0;
    bit mem_mode  = 0;
    logic [31:0] mem_seed = 32'h1234_5678;

    bit pending = 0;
    bit stalling = 0;
    int pend_cnt = 0;
    int stall_left = 0;
    logic [31:0] pend_addr, stall_addr;

    logic [31:0] req_log[$];
    logic [4:0]  off_log[$];
    int data_we_cnt = 0, tag_we_cnt = 0, done_cnt = 0, inval_cnt = 0;
    int bad_order = 0, addr_unstable = 0;
    int last_inval_cyc = -1, last_inval_idx = -1, last_done_cyc = -1;
    logic [31:0] cache_data [128][8];
    logic [19:0] tag_arr [128];
    bit          valid_arr [128];

    int r0, o0, w0, t0, d0, i0;
    int exp_done = 0;

    // Backing memory contents as a function of byte address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_mode == 1'b0) return 32'hA000_0000 + {29'd0, a[4:2]};
        return (a * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    function automatic logic [2:0] exp_start(input logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        return a[4:2];
`else
        return 3'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responder and observer of the cache write ports
    initial begin
        bus_if.mem_req_ready = 1'b0;
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus_if.mem_req_ready = 1'b0;
            bus_if.mem_rsp_valid = 1'b0;
            bus_if.mem_rsp_data  = '0;
            if (!reset) begin
                pending  = 0;
                stalling = 0;
            end else if (pending) begin
                if (pend_cnt == 0) begin
                    bus_if.mem_rsp_valid = 1'b1;
                    bus_if.mem_rsp_data  = mem_word(pend_addr);
                    pending = 0;
                end else begin
                    pend_cnt--;
                end
            end else if (bus_if.mem_req_valid) begin
                if (!stalling) begin
                    stalling   = 1;
                    stall_left = rand_mode ? int'($urandom_range(0, 4)) : stall_cfg;
                    stall_addr = bus_if.mem_req_addr;
                end else if (bus_if.mem_req_addr !== stall_addr) begin
                    addr_unstable++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus_if.mem_req_ready = 1'b1;
                    stalling  = 0;
                    pending   = 1;
                    pend_addr = bus_if.mem_req_addr;
                    pend_cnt  = rand_mode ? int'($urandom_range(0, 3)) : delay_cfg;
                    req_log.push_back(bus_if.mem_req_addr);
                end
            end
            #1;
            if (bus_if.data_we) begin
                if (valid_arr[bus_if.data_index]) bad_order++;
                cache_data[bus_if.data_index][bus_if.data_offset[4:2]] = bus_if.data_wdata;
                off_log.push_back(bus_if.data_offset);
                data_we_cnt++;
            end
            if (bus_if.valid_we) begin
                valid_arr[bus_if.data_index] = bus_if.valid_wdata;
                if (!bus_if.valid_wdata) begin
                    inval_cnt++;
                    last_inval_cyc = cyc;
                    last_inval_idx = int'(bus_if.data_index);
                end
            end
            if (bus_if.tag_we) begin
                tag_arr[bus_if.data_index] = bus_if.tag_wdata;
                tag_we_cnt++;
            end
            if (bus_if.refill_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic snap();
        r0 = req_log.size();
        o0 = off_log.size();
        w0 = data_we_cnt;
        t0 = tag_we_cnt;
        d0 = done_cnt;
        i0 = inval_cnt;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic start_miss(input logic [31:0] a, output int c0);
        check("accept_ready", bus_if.miss_ready, 1);
        bus_if.miss_req  = 1'b1;
        bus_if.miss_addr = a;
        c0 = cyc;
        @(negedge clk);
        bus_if.miss_req  = 1'b0;
        bus_if.miss_addr = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        exp_done++;
        check("refill_timeout", done_cnt > d0, 1);
    endtask

    task automatic verify(input logic [31:0] a, input string nm);
        logic [31:0] base;
        logic [2:0]  w;
        logic [6:0]  idx;
        base = {a[31:5], 5'b0};
        idx  = a[11:5];
        check({nm, "_req_count"}, req_log.size() - r0, 8);
        for (int i = 0; i < 8; i++) begin
            w = exp_start(a) + 3'(i);
            check({nm, "_req_addr"}, req_log[r0 + i], base + {27'd0, w, 2'b00});
            check({nm, "_data_offset"}, off_log[o0 + i], {w, 2'b00});
            check({nm, "_data_word"}, cache_data[idx][i], mem_word(base + 32'(i * 4)));
        end
        check({nm, "_data_writes"}, data_we_cnt - w0, 8);
        check({nm, "_tag_writes"}, tag_we_cnt - t0, 1);
        check({nm, "_tag"}, tag_arr[idx], a[31:12]);
        check({nm, "_valid"}, valid_arr[idx], 1);
        check({nm, "_inval_first"}, bad_order, 0);
    endtask

    initial begin
        logic [31:0] a, a2, a3;
        int c0, c1;
        bus_if.miss_req  = 1'b1;
        bus_if.miss_addr = $urandom;
        mem_seed = $urandom;
        reset = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_miss_ready", bus_if.miss_ready, 1);
        check("rst_ctrl_zero", {bus_if.refill_done, bus_if.mem_req_valid, bus_if.data_we,
                                bus_if.tag_we, bus_if.valid_we, bus_if.valid_wdata}, 0);
        check("rst_req_addr", bus_if.mem_req_addr, 0);
        check("rst_data_bus", {bus_if.data_index, bus_if.data_offset, bus_if.data_wdata}, 0);
        check("rst_tag_wdata", bus_if.tag_wdata, 0);
        @(negedge clk);
        reset = 1'b1;
        bus_if.miss_req = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_ready", bus_if.miss_ready, 1);
        check("post_rst_no_req", bus_if.mem_req_valid, 0);
        check("post_rst_no_inval", inval_cnt, 0);
        @(negedge clk);

        // Basic refill with zero-wait memory
        a = 32'h0001_2040;
        snap();
        start_miss(a, c0);
        wait_done();
        check("basic_inval_cycle", last_inval_cyc - c0, 1);
        check("basic_inval_index", last_inval_idx, 2);
        check("basic_commit_cycle", last_done_cyc - c0, 18);
        check("basic_ready_cycle", cyc - c0, 19);
        check("basic_ready_again", bus_if.miss_ready, 1);
        verify(a, "basic");
        #1;
        check("basic_done_one_cycle", bus_if.refill_done, 0);
        @(negedge clk);

        // Critical-word-first ordering (or plain order when disabled)
        a = 32'h0000_001C;
        snap();
        start_miss(a, c0);
        wait_done();
        verify(a, "cwf");
        @(negedge clk);

        // Backpressure: 5 stalled request cycles, responses 3 cycles late
        mem_mode = 1;
        stall_cfg = 5;
        delay_cfg = 3;
        a = $urandom;
        snap();
        start_miss(a, c0);
        wait_done();
        verify(a, "bp");
        check("bp_addr_stable", addr_unstable, 0);
        check("bp_commit_cycle", last_done_cyc - c0, 82);
        stall_cfg = 0;
        delay_cfg = 6;
        @(negedge clk);

        // Busy miss ignored during WAIT, back-to-back miss after refill_done
        a  = $urandom;
        a2 = ~a;
        snap();
        start_miss(a, c0);
        for (int i = 0; i < 300 && (req_log.size() - r0) < 2; i++) @(negedge clk);
        @(negedge clk);
        bus_if.miss_req  = 1'b1;
        bus_if.miss_addr = a2;
        #1;
        check("busy_not_ready", bus_if.miss_ready, 0);
        @(negedge clk);
        bus_if.miss_req = 1'b0;
        wait_done();
        verify(a, "busy");
        check("busy_single_inval", inval_cnt - i0, 1);
        a3 = $urandom;
        snap();
        start_miss(a3, c1);
        wait_done();
        check("b2b_inval_cycle", last_inval_cyc - c1, 1);
        verify(a3, "b2b");
        delay_cfg = 0;
        @(negedge clk);

        // Reset after the third data write of a refill to valid line 2
        mem_mode = 0;
        a = 32'h00AB_C040;
        snap();
        start_miss(a, c0);
        for (int i = 0; i < 300 && (data_we_cnt - w0) < 3; i++) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready", bus_if.miss_ready, 1);
        check("midrst_idle_outputs", {bus_if.mem_req_valid, bus_if.data_we, bus_if.tag_we,
                                      bus_if.valid_we, bus_if.refill_done}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_data_writes", data_we_cnt - w0, 3);
        check("midrst_no_tag_we", tag_we_cnt - t0, 0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_line_invalid", valid_arr[2], 0);
        check("midrst_old_tag", tag_arr[2], 20'h00012);
        check("midrst_inval_first", bad_order, 0);

        // Randomized addresses, stalls and response delays
        mem_mode = 1;
        rand_mode = 1;
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            snap();
            start_miss(a, c0);
            wait_done();
            verify(a, "rand");
            @(negedge clk);
        end

        check("total_refill_done", done_cnt, exp_done);
        check("total_addr_stable", addr_unstable, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
# icache_refill

Line-fill engine for the 4 KB direct-mapped instruction cache: the write side of the cache arrays. On a miss it invalidates the target line, fetches all eight 32-bit words of the 32-byte line from main memory through a request/response handshake, writes them into the data array in big-endian byte order, then writes the tag and sets the valid bit. It sits between the fetch stage's miss signal and the memory port, and drives the cache's tag, data and valid-bit write ports.

## Interface
- TAG_WIDTH, 20, address tag bits, addr[31:12]
- INDEX_WIDTH, 7, line index bits, addr[11:5]
- OFFSET_WIDTH, 5, byte offset bits, addr[4:0]; words per line = 2^(OFFSET_WIDTH-2) = 8

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- miss_req  in  1  fetch stage reports a miss
- miss_addr  in  32  missing fetch address
- miss_ready  out  1  engine idle, can accept a miss
- refill_done  out  1  one-cycle pulse, line now valid
- mem_req_valid  out  1  word read request
- mem_req_addr  out  32  word-aligned request address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read data, byte [31:24] at lowest address
- data_we  out  1  data array write enable (4 bytes)
- data_index  out  INDEX_WIDTH  line being written
- data_offset  out  OFFSET_WIDTH  byte offset of the first byte, always a multiple of 4
- data_wdata  out  32  bytes for offsets +0..+3 = [31:24],[23:16],[15:8],[7:0]
- tag_we  out  1  tag write enable
- tag_wdata  out  TAG_WIDTH  tag written at data_index
- valid_we  out  1  valid-bit write enable
- valid_wdata  out  1  valid-bit value written at data_index

## Operation
- States: IDLE, INVAL, REQ, WAIT, COMMIT.
- IDLE: miss_ready=1. On miss_req=1, latch tag=miss_addr[31:12], index=miss_addr[11:5], start word, word count=0; go to INVAL. miss_req in any other state is ignored.
- INVAL: valid_we=1, valid_wdata=0 at the latched index for one cycle; go to REQ. The line is never left marked valid with partial data.
- REQ: mem_req_valid=1, mem_req_addr={tag,index,word,2'b00}; address stays stable until mem_req_ready=1, then go to WAIT.
- WAIT: when mem_rsp_valid=1, data_we=1 (combinational), data_offset=word*4, data_wdata=mem_rsp_data; increment the word modulo 8 and the count. If the count reaches 8, go to COMMIT, otherwise go to REQ. mem_rsp_valid outside WAIT is ignored.
- COMMIT: tag_we=1, tag_wdata=latched tag, valid_we=1, valid_wdata=1, refill_done=1, all in the same cycle; go to IDLE.
- data_index always presents the latched index.

## Timing
- Reset (reset=0) forces state to IDLE. Outputs during reset: miss_ready=1; all others 0, including the address and data buses.
- Reset mid-refill: abandon the refill immediately and return to IDLE. The line stays invalid if INVAL has completed; no tag write occurs.
- Outstanding requests: at most one. Request acceptance and response are never in the same cycle.
- With mem_req_ready held at 1 and the response one cycle after acceptance:
  - miss accepted in cycle 0
  - INVAL in cycle 1
  - words in cycles 2–17, two cycles per word
  - COMMIT and refill_done in cycle 18
  - miss_ready=1 again in cycle 19
- Memory stalls extend REQ or WAIT indefinitely, with no timeout.

## Configuration
- ICACHE_CRITICAL_WORD_FIRST_EN defined: the start word is miss_addr[4:2]. The word index wraps 7→0, and all eight words are still fetched.
- ICACHE_CRITICAL_WORD_FIRST_EN undefined: the start word is always 0, fetching words 0..7 in order, and miss_addr[4:0] is ignored.

## Test plan
- Reset: hold reset=0 with miss_req=1 → miss_ready=1, all other outputs 0, no state change. Release reset → IDLE.
- Basic refill: miss_addr=0x0001_2040, zero-wait memory returning 0xA0000000+word → valid cleared at index 2 in cycle 1.
  - Requests go to 0x00012040..0x0001205C.
  - data_offset takes 0,4,..,28.
  - COMMIT in cycle 18: tag 0x00012 written, valid=1, refill_done for exactly one cycle.
- Critical word first: with the macro defined, miss_addr=0x0000_001C → request order 0x1C,0x00,0x04,..,0x18, wrapping after word 7. Without the macro, the order is 0x00..0x1C.
- Backpressure: mem_req_ready=0 for 5 cycles, and the response delayed by 3 cycles per word → mem_req_addr stable while stalled. data_we fires exactly once per response; there are 8 data writes in total.
- Busy miss: a second miss_req during WAIT → ignored, miss_ready=0, no change to the latched tag. A miss_req after refill_done is accepted.
- Reset mid-refill: assert reset after the 3rd data write → IDLE immediately. No tag_we or refill_done occurs, and the line's valid bit remains 0.
